rr_response_router: RTL and testbench
=====================================

RR_RESPONSE_ROUTER -- requirements
Module: rr_response_router

Interface
REQ-001 Parameter VALUE_WIDTH, default 8, SHALL set the PLM data and response value width.
REQ-002 Parameter NCONSUMERS, default 2, SHALL set the number of consumers (>=2).
REQ-003 Parameter NBANKS, default 1, SHALL set the number of PLM banks.
REQ-004 Parameter NPORTS, default 2, SHALL set ports per bank (1 or 2); NKERNELS = NBANKS*NPORTS (>1).
REQ-005 Parameter PLM_LATENCY, default 1, SHALL set the cycles from a grant to valid plm_outputs (1..4).
REQ-006 clk  input  1  SHALL be the single clock; all state changes on posedge clk.
REQ-007 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-008 grant_valid  input  [NKERNELS]  SHALL flag that kernel k issued an eligible request this cycle.
REQ-009 grant_consumer  input  [$clog2(NCONSUMERS)] x NKERNELS  SHALL give the consumer index granted by kernel k.
REQ-010 grant_wr  input  [NKERNELS]  SHALL flag that the grant of kernel k was a write.
REQ-011 plm_outputs  input  [VALUE_WIDTH] x NKERNELS  SHALL carry PLM read data, valid PLM_LATENCY cycles after the grant.
REQ-012 resp_ready  input  [NCONSUMERS]  SHALL flag that consumer c accepts its response this cycle.
REQ-013 resp_valid  output  [NCONSUMERS]  SHALL flag a held response for consumer c.
REQ-014 resp_value  output  [VALUE_WIDTH] x NCONSUMERS  SHALL carry the held response data.
REQ-015 resp_is_ack  output  [NCONSUMERS]  SHALL flag the held response as a write acknowledge.
REQ-016 overflow  output  [NCONSUMERS]  SHALL be a sticky flag: response dropped for consumer c.
REQ-017 collision  output  1  SHALL be a sticky flag: two kernels delivered to one consumer in the same cycle.

Function
REQ-018 Each kernel SHALL delay {grant_valid, grant_consumer, grant_wr} through PLM_LATENCY register stages; stage output aligns with plm_outputs.
REQ-019 A delivery from kernel k SHALL occur when its delayed valid is 1 and (delayed wr is 0, or RR_RESP_WRITE_ACK_EN is defined).
REQ-020 A read delivery SHALL load plm_outputs[k] into consumer c's hold register, resp_is_ack=0; resp_valid rises the next edge (grant-to-resp_valid latency = PLM_LATENCY+1).
REQ-021 Each consumer hold register SHALL be FULL (resp_valid=1) or EMPTY; EMPTY->FULL on delivery, FULL->EMPTY on resp_valid&&resp_ready with no delivery.
REQ-022 FULL with resp_ready=1 and a new delivery in the same cycle SHALL load the new response and remain FULL (no bubble, no overflow).
REQ-023 FULL with resp_ready=0 and a new delivery SHALL keep the held response, drop the new one and set overflow[c].
REQ-024 Two or more kernels delivering to one consumer in one cycle SHALL deliver the lowest kernel index, drop the rest and set collision.
REQ-025 resp_value and resp_is_ack SHALL hold stable while resp_valid=1 and resp_ready=0.
REQ-026 overflow and collision SHALL clear only on reset.
REQ-027 grant_consumer values >= NCONSUMERS SHALL be ignored (no delivery, no flag).

Reset
REQ-028 Reset SHALL clear all delay stages, resp_valid, resp_value, resp_is_ack, overflow and collision to 0 immediately; in-flight grants are discarded.
REQ-029 The first grant accepted is the one sampled on the first posedge clk after reset deasserts.

Configuration
REQ-030 With RR_RESP_WRITE_ACK_EN defined, a write grant SHALL deliver resp_value=0, resp_is_ack=1; without it, write grants SHALL produce no delivery and resp_is_ack SHALL be tied 0.

Structure
REQ-031 Package rr_pkg SHALL hold NKERNELS and consumer-index width derivations and the response record typedef {value, is_ack}.
REQ-032 Sub-module rr_grant_delay_line SHALL implement one kernel's PLM_LATENCY-deep grant pipeline; one instance per kernel.

Verification
REQ-033 NPORTS=2, PLM_LATENCY=1: grant k0->c1 read at cycle 5, plm_outputs[0]=8'hA5 at cycle 6 -> resp_valid[1]=1, resp_value[1]=8'hA5 at cycle 7.
REQ-034 resp_ready[0]=0, two reads to c0 (8'h11 then 8'h22) -> resp_value[0] stays 8'h11, overflow[0]=1.
REQ-035 Kernels 0 and 1 both deliver to c0 (8'h33, 8'h44) same cycle -> resp_value[0]=8'h33, collision=1.
REQ-036 Held response with resp_ready=1 and new delivery 8'h55 same cycle -> resp_valid stays 1, resp_value=8'h55, overflow=0.
REQ-037 Write grant to c1: with RR_RESP_WRITE_ACK_EN -> resp_valid[1]=1, resp_is_ack[1]=1, value 0; without -> resp_valid[1] stays 0.
REQ-038 PLM_LATENCY=3, reset asserted one cycle after grant -> no resp_valid after reset, all flags 0.

Source files
------------

// File: rtl/rr_pkg.sv
// Shared types and parameter derivations for the response router.
// Kernel count and consumer-index width come from the module parameters
// through the helper functions below. rr_resp_t is sized for the widest
// supported value (RR_MAX_VALUE_WIDTH); VALUE_WIDTH must not exceed it.
package rr_pkg;

    localparam int RR_MAX_VALUE_WIDTH = 64;

    // One held response: read data or a write acknowledge.
    typedef struct packed {
        logic [RR_MAX_VALUE_WIDTH-1:0] value;
        logic                          is_ack;
    } rr_resp_t;

    // Total PLM ports, one requesting kernel per port.
    function automatic int rr_nkernels(input int nbanks, input int nports);
        return nbanks * nports;
    endfunction

    // Width of a consumer index; never narrower than one bit.
    function automatic int rr_cidx_width(input int nconsumers);
        return (nconsumers > 1) ? $clog2(nconsumers) : 1;
    endfunction

endpackage

// File: rtl/rr_response_router_if.sv
// Grant, PLM data and response bundle between the request arbiters,
// the PLM and the consumers. The router is the slave; the surrounding
// system (arbiters, PLM and consumers together) is the master.
interface rr_response_router_if #(
    parameter int VALUE_WIDTH = 8,
    parameter int NCONSUMERS  = 2,
    parameter int NKERNELS    = 2
);
    import rr_pkg::*;

    localparam int CIDX_W = rr_cidx_width(NCONSUMERS);

    logic [NKERNELS-1:0]                   grant_valid;
    logic [NKERNELS-1:0][CIDX_W-1:0]       grant_consumer;
    logic [NKERNELS-1:0]                   grant_wr;
    logic [NKERNELS-1:0][VALUE_WIDTH-1:0]  plm_outputs;
    logic [NCONSUMERS-1:0]                 resp_ready;
    logic [NCONSUMERS-1:0]                 resp_valid;
    logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] resp_value;
    logic [NCONSUMERS-1:0]                 resp_is_ack;
    logic [NCONSUMERS-1:0]                 overflow;
    logic                                  collision;

    modport master (
        output grant_valid, grant_consumer, grant_wr, plm_outputs, resp_ready,
        input  resp_valid, resp_value, resp_is_ack, overflow, collision
    );

    modport slave (
        input  grant_valid, grant_consumer, grant_wr, plm_outputs, resp_ready,
        output resp_valid, resp_value, resp_is_ack, overflow, collision
    );

endinterface

// File: rtl/rr_grant_delay_line.sv
// One kernel's grant pipeline: delays {valid, consumer, wr} by
// PLM_LATENCY clocks so the last stage lines up with that kernel's
// plm_outputs. Every stage is cleared by reset, so a grant in flight
// when reset hits never turns into a delivery.
module rr_grant_delay_line #(
    parameter int PLM_LATENCY = 1,
    parameter int CIDX_W      = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              grant_valid,
    input  logic [CIDX_W-1:0] grant_consumer,
    input  logic              grant_wr,
    output logic              dly_valid,
    output logic [CIDX_W-1:0] dly_consumer,
    output logic              dly_wr
);

    logic [PLM_LATENCY-1:0]             valid_q;
    logic [PLM_LATENCY-1:0]             wr_q;
    logic [PLM_LATENCY-1:0][CIDX_W-1:0] consumer_q;

    // Shift the grant one stage per clock; stage 0 samples the inputs.
    // NOTE: non-blocking assignments let every stage read its neighbour's
    // old value, which is what makes this a shift register, not a wire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= '0;
            wr_q       <= '0;
            consumer_q <= '0;
        end else begin
            valid_q[0]    <= grant_valid;
            wr_q[0]       <= grant_wr;
            consumer_q[0] <= grant_consumer;
            for (int i = 1; i < PLM_LATENCY; i++) begin
                valid_q[i]    <= valid_q[i-1];
                wr_q[i]       <= wr_q[i-1];
                consumer_q[i] <= consumer_q[i-1];
            end
        end
    end

    assign dly_valid    = valid_q[PLM_LATENCY-1];
    assign dly_wr       = wr_q[PLM_LATENCY-1];
    assign dly_consumer = consumer_q[PLM_LATENCY-1];

endmodule

// File: rtl/rr_response_router.sv
// Response router: realigns each kernel's grant with its PLM read data,
// routes the result to the granted consumer's single-entry hold register
// and raises sticky overflow/collision flags when responses are dropped.
// Optional feature: define RR_RESP_WRITE_ACK_EN to turn write grants into
// acknowledge responses (value 0, resp_is_ack 1); by default write grants
// produce nothing and resp_is_ack stays 0.
module rr_response_router
    import rr_pkg::*;
#(
    parameter int VALUE_WIDTH = 8,
    parameter int NCONSUMERS  = 2,
    parameter int NBANKS      = 1,
    parameter int NPORTS      = 2,
    parameter int PLM_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    rr_response_router_if.slave  bus
);

    localparam int NKERNELS = rr_nkernels(NBANKS, NPORTS);
    localparam int CIDX_W   = rr_cidx_width(NCONSUMERS);

    // Grant as seen in the cycle its PLM data is valid.
    logic [NKERNELS-1:0]             dly_valid;
    logic [NKERNELS-1:0]             dly_wr;
    logic [NKERNELS-1:0][CIDX_W-1:0] dly_consumer;

    // Per-kernel delivery request and the response it would deliver.
    logic [NKERNELS-1:0] deliver;
    rr_resp_t            kernel_resp [NKERNELS];

    // Per-consumer winner of this cycle's deliveries.
    logic [NCONSUMERS-1:0] hit;
    logic [NCONSUMERS-1:0] multi;
    rr_resp_t              win_resp [NCONSUMERS];

    // Hold registers and sticky flags.
    logic [NCONSUMERS-1:0] valid_q;
    logic [NCONSUMERS-1:0] overflow_q;
    logic                  collision_q;
    rr_resp_t              hold_q [NCONSUMERS];

    for (genvar k = 0; k < NKERNELS; k++) begin : g_kernel
        rr_grant_delay_line #(
            .PLM_LATENCY (PLM_LATENCY),
            .CIDX_W      (CIDX_W)
        ) u_delay (
            .clk            (clk),
            .reset          (reset),
            .grant_valid    (bus.grant_valid[k]),
            .grant_consumer (bus.grant_consumer[k]),
            .grant_wr       (bus.grant_wr[k]),
            .dly_valid      (dly_valid[k]),
            .dly_consumer   (dly_consumer[k]),
            .dly_wr         (dly_wr[k])
        );
    end

    // Qualify each aligned grant and shape the response it carries;
    // out-of-range consumer indices never deliver.
    always_comb begin
        deliver = '0;
        for (int k = 0; k < NKERNELS; k++) begin
            kernel_resp[k] = '0;
`ifdef RR_RESP_WRITE_ACK_EN
            deliver[k]            = dly_valid[k] && (int'(dly_consumer[k]) < NCONSUMERS);
            kernel_resp[k].is_ack = dly_wr[k];
            kernel_resp[k].value  = dly_wr[k] ? '0
                                              : RR_MAX_VALUE_WIDTH'(bus.plm_outputs[k]);
`else
            deliver[k]            = dly_valid[k] && !dly_wr[k]
                                    && (int'(dly_consumer[k]) < NCONSUMERS);
            kernel_resp[k].is_ack = 1'b0;
            kernel_resp[k].value  = RR_MAX_VALUE_WIDTH'(bus.plm_outputs[k]);
`endif
        end
    end

    // Pick the lowest-index kernel per consumer and note any extra ones.
    // NOTE: every output of this block gets a default before the loops, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        hit   = '0;
        multi = '0;
        for (int c = 0; c < NCONSUMERS; c++) begin
            win_resp[c] = '0;
        end
        for (int c = 0; c < NCONSUMERS; c++) begin
            for (int k = 0; k < NKERNELS; k++) begin
                if (deliver[k] && (int'(dly_consumer[k]) == c)) begin
                    if (hit[c]) begin
                        multi[c] = 1'b1;
                    end else begin
                        hit[c]      = 1'b1;
                        win_resp[c] = kernel_resp[k];
                    end
                end
            end
        end
    end

    // Hold-register state: load on delivery when empty or being drained,
    // drop and flag when full and stalled, empty on a plain handshake.
    // NOTE: the hold registers are reset as well as the valid bits, because
    // resp_value and resp_is_ack are required to read 0 straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= '0;
            overflow_q  <= '0;
            collision_q <= 1'b0;
            for (int c = 0; c < NCONSUMERS; c++) begin
                hold_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCONSUMERS; c++) begin
                if (hit[c]) begin
                    if (!valid_q[c] || bus.resp_ready[c]) begin
                        hold_q[c]  <= win_resp[c];
                        valid_q[c] <= 1'b1;
                    end else begin
                        overflow_q[c] <= 1'b1;
                    end
                end else if (valid_q[c] && bus.resp_ready[c]) begin
                    valid_q[c] <= 1'b0;
                end
            end
            if (|multi) begin
                collision_q <= 1'b1;
            end
        end
    end

    // Drive the consumer-facing outputs straight from the registers; the
    // held is_ack bit is constant 0 when write acknowledges are disabled.
    always_comb begin
        bus.resp_valid = valid_q;
        bus.overflow   = overflow_q;
        bus.collision  = collision_q;
        for (int c = 0; c < NCONSUMERS; c++) begin
            bus.resp_value[c]  = hold_q[c].value[VALUE_WIDTH-1:0];
            bus.resp_is_ack[c] = hold_q[c].is_ack;
        end
    end

endmodule

// File: tb/tb_rr_response_router.sv
// Directed bench for rr_response_router. Two instances share the clock:
// dut_a uses the defaults (2 consumers, 2 kernels, PLM_LATENCY 1) and
// dut_b uses 3 consumers and PLM_LATENCY 3 for latency, out-of-range and
// reset-flush cases. Expected responses are queued per consumer when a
// grant is issued and popped when the consumer takes the response.
module tb_rr_response_router;

    localparam int VW = 8;

    typedef struct packed {
        logic [VW-1:0] value;
        logic          is_ack;
    } exp_t;

    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t sb_a [2][$];
    exp_t sb_b [3][$];

    rr_response_router_if #(.VALUE_WIDTH(VW), .NCONSUMERS(2), .NKERNELS(2)) bus_a ();
    rr_response_router_if #(.VALUE_WIDTH(VW), .NCONSUMERS(3), .NKERNELS(2)) bus_b ();

    rr_response_router #(
        .VALUE_WIDTH(VW), .NCONSUMERS(2), .NBANKS(1), .NPORTS(2), .PLM_LATENCY(1)
    ) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (bus_a)
    );

    rr_response_router #(
        .VALUE_WIDTH(VW), .NCONSUMERS(3), .NBANKS(1), .NPORTS(2), .PLM_LATENCY(3)
    ) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [VW-1:0] v, input logic ack);
        exp_t e;
        e.value  = v;
        e.is_ack = ack;
        return e;
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        bus_a.grant_valid    = '0;
        bus_a.grant_consumer = '0;
        bus_a.grant_wr       = '0;
        bus_a.plm_outputs    = '0;
    endtask

    task automatic idle_b();
        bus_b.grant_valid    = '0;
        bus_b.grant_consumer = '0;
        bus_b.grant_wr       = '0;
        bus_b.plm_outputs    = '0;
    endtask

    task automatic grant_a(input int k, input int c, input logic wr);
        bus_a.grant_valid[k]    = 1'b1;
        bus_a.grant_consumer[k] = 1'(c);
        bus_a.grant_wr[k]       = wr;
    endtask

    task automatic grant_b(input int k, input int c, input logic wr);
        bus_b.grant_valid[k]    = 1'b1;
        bus_b.grant_consumer[k] = 2'(c);
        bus_b.grant_wr[k]       = wr;
    endtask

    // Compare the held response of consumer c against the scoreboard head.
    task automatic pop_check_a(input int c, input string tag);
        exp_t e;
        check({tag, "_valid"}, 64'(bus_a.resp_valid[c]), 64'(1));
        check({tag, "_queued"}, 64'(sb_a[c].size() > 0), 64'(1));
        if (sb_a[c].size() > 0) begin
            e = sb_a[c].pop_front();
            check({tag, "_value"}, 64'(bus_a.resp_value[c]), 64'(e.value));
            check({tag, "_is_ack"}, 64'(bus_a.resp_is_ack[c]), 64'(e.is_ack));
        end
    endtask

    task automatic pop_check_b(input int c, input string tag);
        exp_t e;
        check({tag, "_valid"}, 64'(bus_b.resp_valid[c]), 64'(1));
        check({tag, "_queued"}, 64'(sb_b[c].size() > 0), 64'(1));
        if (sb_b[c].size() > 0) begin
            e = sb_b[c].pop_front();
            check({tag, "_value"}, 64'(bus_b.resp_value[c]), 64'(e.value));
            check({tag, "_is_ack"}, 64'(bus_b.resp_is_ack[c]), 64'(e.is_ack));
        end
    endtask

    // Accept consumer c's response for one cycle.
    task automatic drain_a(input int c, input string tag);
        bus_a.resp_ready[c] = 1'b1;
        pop_check_a(c, tag);
        tick();
        bus_a.resp_ready[c] = 1'b0;
    endtask

    task automatic drain_b(input int c, input string tag);
        bus_b.resp_ready[c] = 1'b1;
        pop_check_b(c, tag);
        tick();
        bus_b.resp_ready[c] = 1'b0;
    endtask

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        idle_a();
        idle_b();
        bus_a.resp_ready = '0;
        bus_b.resp_ready = '0;
        tick();
        tick();

        // Reset state
        check("rst_a_valid",     64'(bus_a.resp_valid),  64'(0));
        check("rst_a_value",     64'(bus_a.resp_value),  64'(0));
        check("rst_a_is_ack",    64'(bus_a.resp_is_ack), 64'(0));
        check("rst_a_overflow",  64'(bus_a.overflow),    64'(0));
        check("rst_a_collision", 64'(bus_a.collision),   64'(0));
        check("rst_b_valid",     64'(bus_b.resp_valid),  64'(0));

        reset_a = 1'b0;
        tick();

        // Read k0 -> c1, data 0xA5 one cycle after the grant
        grant_a(0, 1, 1'b0);
        sb_a[1].push_back(mk(8'hA5, 1'b0));
        tick();
        idle_a();
        bus_a.plm_outputs[0] = 8'hA5;
        check("rd_early_valid", 64'(bus_a.resp_valid[1]), 64'(0));
        tick();
        idle_a();
        check("rd_other_valid", 64'(bus_a.resp_valid[0]), 64'(0));
        drain_a(1, "rd_c1");
        check("rd_emptied", 64'(bus_a.resp_valid[1]), 64'(0));

        // Overflow: c0 stalled, 0x11 then 0x22
        grant_a(0, 0, 1'b0);
        sb_a[0].push_back(mk(8'h11, 1'b0));
        tick();
        idle_a();
        grant_a(1, 0, 1'b0);
        bus_a.plm_outputs[0] = 8'h11;
        tick();
        idle_a();
        bus_a.plm_outputs[1] = 8'h22;
        check("ovf_first_value", 64'(bus_a.resp_value[0]), 64'(8'h11));
        check("ovf_not_yet",     64'(bus_a.overflow),      64'(0));
        tick();
        idle_a();
        check("ovf_kept_value", 64'(bus_a.resp_value[0]), 64'(8'h11));
        check("ovf_flags",      64'(bus_a.overflow),      64'(2'b01));
        tick();
        check("ovf_stable_value", 64'(bus_a.resp_value[0]), 64'(8'h11));
        drain_a(0, "ovf_c0");

        // Collision: k0 (0x33) and k1 (0x44) both to c0
        check("col_before", 64'(bus_a.collision), 64'(0));
        grant_a(0, 0, 1'b0);
        grant_a(1, 0, 1'b0);
        sb_a[0].push_back(mk(8'h33, 1'b0));
        tick();
        idle_a();
        bus_a.plm_outputs[0] = 8'h33;
        bus_a.plm_outputs[1] = 8'h44;
        tick();
        idle_a();
        check("col_flag",        64'(bus_a.collision), 64'(1));
        check("col_ovf_sticky",  64'(bus_a.overflow),  64'(2'b01));
        drain_a(0, "col_c0");

        // Back-to-back on c1: drain 0x66 while 0x55 arrives
        grant_a(0, 1, 1'b0);
        sb_a[1].push_back(mk(8'h66, 1'b0));
        tick();
        idle_a();
        grant_a(1, 1, 1'b0);
        bus_a.plm_outputs[0] = 8'h66;
        tick();
        idle_a();
        bus_a.plm_outputs[1] = 8'h55;
        bus_a.resp_ready[1] = 1'b1;
        pop_check_a(1, "b2b_first");
        sb_a[1].push_back(mk(8'h55, 1'b0));
        tick();
        bus_a.resp_ready[1] = 1'b0;
        idle_a();
        check("b2b_no_bubble", 64'(bus_a.resp_valid[1]), 64'(1));
        drain_a(1, "b2b_second");
        check("b2b_no_overflow", 64'(bus_a.overflow[1]), 64'(0));

        // Write grant k1 -> c1 with non-zero PLM data on the aligned cycle
        grant_a(1, 1, 1'b1);
`ifdef RR_RESP_WRITE_ACK_EN
        sb_a[1].push_back(mk(8'h00, 1'b1));
`endif
        tick();
        idle_a();
        bus_a.plm_outputs[1] = 8'hEE;
        tick();
        idle_a();
`ifdef RR_RESP_WRITE_ACK_EN
        drain_a(1, "wr_ack");
`else
        check("wr_no_resp", 64'(bus_a.resp_valid[1]), 64'(0));
        tick();
        check("wr_no_resp_later", 64'(bus_a.resp_valid), 64'(0));
`endif

        // dut_b: first grant sampled on the first edge after reset release
        reset_b = 1'b0;
        grant_b(1, 2, 1'b0);
        sb_b[2].push_back(mk(8'h9C, 1'b0));
        tick();
        idle_b();
        check("lat3_c1", 64'(bus_b.resp_valid[2]), 64'(0));
        tick();
        check("lat3_c2", 64'(bus_b.resp_valid[2]), 64'(0));
        tick();
        bus_b.plm_outputs[1] = 8'h9C;
        check("lat3_c3", 64'(bus_b.resp_valid[2]), 64'(0));
        tick();
        idle_b();
        drain_b(2, "lat3_c2resp");

        // Out-of-range consumer index 3 is ignored
        grant_b(0, 3, 1'b0);
        tick();
        idle_b();
        tick();
        tick();
        bus_b.plm_outputs[0] = 8'h5A;
        tick();
        idle_b();
        tick();
        check("oor_valid",     64'(bus_b.resp_valid), 64'(0));
        check("oor_overflow",  64'(bus_b.overflow),   64'(0));
        check("oor_collision", 64'(bus_b.collision),  64'(0));

        // Build up state and flags on dut_b, then reset with a grant in flight
        grant_b(0, 0, 1'b0);
        tick();
        idle_b();
        grant_b(0, 1, 1'b0);
        grant_b(1, 1, 1'b0);
        tick();
        idle_b();
        grant_b(0, 0, 1'b0);
        tick();
        idle_b();
        bus_b.plm_outputs[0] = 8'h77;
        tick();
        bus_b.plm_outputs[0] = 8'h12;
        bus_b.plm_outputs[1] = 8'h34;
        tick();
        bus_b.plm_outputs[0] = 8'h88;
        bus_b.plm_outputs[1] = 8'h00;
        tick();
        idle_b();
        check("pre_rst_valid",     64'(bus_b.resp_valid),    64'(3'b011));
        check("pre_rst_value0",    64'(bus_b.resp_value[0]), 64'(8'h77));
        check("pre_rst_value1",    64'(bus_b.resp_value[1]), 64'(8'h12));
        check("pre_rst_collision", 64'(bus_b.collision),     64'(1));
        check("pre_rst_overflow",  64'(bus_b.overflow),      64'(3'b001));
        grant_b(1, 2, 1'b0);
        tick();
        idle_b();
        reset_b = 1'b1;
        #1;
        check("async_rst_valid",     64'(bus_b.resp_valid), 64'(0));
        check("async_rst_value",     64'(bus_b.resp_value), 64'(0));
        check("async_rst_overflow",  64'(bus_b.overflow),   64'(0));
        check("async_rst_collision", 64'(bus_b.collision),  64'(0));
        tick();
        reset_b = 1'b0;
        bus_b.plm_outputs = '1;
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        idle_b();
        check("flush_valid",     64'(bus_b.resp_valid), 64'(0));
        check("flush_value",     64'(bus_b.resp_value), 64'(0));
        check("flush_overflow",  64'(bus_b.overflow),   64'(0));
        check("flush_collision", 64'(bus_b.collision),  64'(0));

        // Every queued response was consumed
        check("sb_a_empty", 64'(sb_a[0].size() + sb_a[1].size()), 64'(0));
        check("sb_b_empty", 64'(sb_b[0].size() + sb_b[1].size() + sb_b[2].size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
